// File: rtl/point_tracker.sv
// Purpose : classify each active VGA pixel against a colour threshold, build the
//           bounding box of matching pixels over a frame, report its centre once per frame.
// Latency : EOF pixel sampled on edge N -> o_pointVAL high for the cycle after edge N+1.
// Backpressure: none; the pixel stream is free-running and the point is a one-cycle pulse.
//
// Ports:
//   i_clk, i_rst          pixel clock, synchronous active-high reset
//   i_color/i_h/i_v       pixel colour {R,G,B} (10 bits each) and coordinates
//   i_rendering           pixel is in the visible area
//   o_pointH/o_pointV     reported centre (10'h3FF = no point yet)
//   o_pointVAL            one-cycle pulse when a new point is reported
//   o_count               matching-pixel count of the last completed frame
//
// Optional feature macro: POINT_SMOOTH_EN (average each new centre with the previous point).
module point_tracker #(
    parameter int          FRAME_W    = 640,
    parameter int          FRAME_H    = 480,
    parameter logic [9:0]  R_MAX      = 10'd300,
    parameter logic [9:0]  G_MIN      = 10'd600,
    parameter logic [9:0]  B_MAX      = 10'd300,
    parameter int          MIN_PIXELS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [29:0] i_color,
    input  logic [9:0]  i_h,
    input  logic [9:0]  i_v,
    input  logic        i_rendering,
    output logic [9:0]  o_pointH,
    output logic [9:0]  o_pointV,
    output logic        o_pointVAL,
    output logic [18:0] o_count
);

    localparam logic [10:0] W_LIM  = 11'(FRAME_W);
    localparam logic [10:0] H_LIM  = 11'(FRAME_H);
    localparam logic [9:0]  LAST_H = 10'(FRAME_W - 1);
    localparam logic [9:0]  LAST_V = 10'(FRAME_H - 1);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);
    localparam logic [9:0]  NO_PT  = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  minh_q, minh_d, maxh_q, maxh_d;
    logic [9:0]  minv_q, minv_d, maxv_q, maxv_d;
    logic [18:0] cnt_q, cnt_d;
    logic [9:0]  pointh_q, pointh_d, pointv_q, pointv_d;
    logic        val_q, val_d;
    logic [18:0] count_q, count_d;

    logic [9:0] pix_r, pix_g, pix_b;
    logic       pix_match, sof, eof;

    assign pix_r = i_color[29:20];
    assign pix_g = i_color[19:10];
    assign pix_b = i_color[9:0];

    assign pix_match = i_rendering
                     && ({1'b0, i_h} < W_LIM) && ({1'b0, i_v} < H_LIM)
                     && (pix_r <= R_MAX) && (pix_g >= G_MIN) && (pix_b <= B_MAX);
    assign sof = i_rendering && (i_h == 10'd0) && (i_v == 10'd0);
    assign eof = i_rendering && (i_h == LAST_H) && (i_v == LAST_V);

    // Box centre; sums are 11 bits so max coordinates cannot wrap.
    logic [10:0] cen_h_sum, cen_v_sum;
    logic [9:0]  cen_h, cen_v;
    assign cen_h_sum = {1'b0, minh_q} + {1'b0, maxh_q};
    assign cen_v_sum = {1'b0, minv_q} + {1'b0, maxv_q};
    assign cen_h     = 10'(cen_h_sum >> 1);
    assign cen_v     = 10'(cen_v_sum >> 1);

`ifdef POINT_SMOOTH_EN
    logic [10:0] smo_h_sum, smo_v_sum;
    assign smo_h_sum = {1'b0, pointh_q} + {1'b0, cen_h};
    assign smo_v_sum = {1'b0, pointv_q} + {1'b0, cen_v};
`endif

    // Accumulation base: a SOF (in IDLE or SCAN) starts from an empty box,
    // otherwise the running box continues.
    logic        accumulate;
    logic [9:0]  base_minh, base_maxh, base_minv, base_maxv;
    logic [18:0] base_cnt;

    always_comb begin
        accumulate = ((state_q == IDLE) && sof) || (state_q == SCAN);
        base_minh  = sof ? NO_PT : minh_q;
        base_minv  = sof ? NO_PT : minv_q;
        base_maxh  = sof ? 10'd0 : maxh_q;
        base_maxv  = sof ? 10'd0 : maxv_q;
        base_cnt   = sof ? 19'd0 : cnt_q;
    end

    always_comb begin
        state_d  = state_q;
        minh_d   = minh_q;
        maxh_d   = maxh_q;
        minv_d   = minv_q;
        maxv_d   = maxv_q;
        cnt_d    = cnt_q;
        pointh_d = pointh_q;
        pointv_d = pointv_q;
        val_d    = 1'b0;
        count_d  = count_q;

        if (accumulate) begin
            minh_d = base_minh;
            maxh_d = base_maxh;
            minv_d = base_minv;
            maxv_d = base_maxv;
            cnt_d  = base_cnt;
            if (pix_match) begin
                minh_d = (i_h < base_minh) ? i_h : base_minh;
                maxh_d = (i_h > base_maxh) ? i_h : base_maxh;
                minv_d = (i_v < base_minv) ? i_v : base_minv;
                maxv_d = (i_v > base_maxv) ? i_v : base_maxv;
                cnt_d  = base_cnt + 19'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (sof) state_d = SCAN;
            end
            SCAN: begin
                if (eof && !sof) state_d = REPORT;
            end
            REPORT: begin
                count_d = cnt_q;
                if (cnt_q >= MIN_CNT) begin
                    val_d    = 1'b1;
                    pointh_d = cen_h;
                    pointv_d = cen_v;
`ifdef POINT_SMOOTH_EN
                    // First point after reset is loaded raw; later ones are averaged.
                    if (pointh_q != NO_PT) begin
                        pointh_d = 10'(smo_h_sum >> 1);
                        pointv_d = 10'(smo_v_sum >> 1);
                    end
`endif
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            minh_q   <= NO_PT;
            minv_q   <= NO_PT;
            maxh_q   <= 10'd0;
            maxv_q   <= 10'd0;
            cnt_q    <= 19'd0;
            pointh_q <= NO_PT;
            pointv_q <= NO_PT;
            val_q    <= 1'b0;
            count_q  <= 19'd0;
        end else begin
            state_q  <= state_d;
            minh_q   <= minh_d;
            minv_q   <= minv_d;
            maxh_q   <= maxh_d;
            maxv_q   <= maxv_d;
            cnt_q    <= cnt_d;
            pointh_q <= pointh_d;
            pointv_q <= pointv_d;
            val_q    <= val_d;
            count_q  <= count_d;
        end
    end

    assign o_pointH   = pointh_q;
    assign o_pointV   = pointv_q;
    assign o_pointVAL = val_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_point_tracker.sv
// Bench for point_tracker: sparse frames (SOF pixel, pixels of interest, EOF pixel)
// driven one per clock; every cycle the outputs are compared with a frame-level model
// that keeps the list of matching coordinates and derives the box with plain arithmetic.
module tb_point_tracker;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [29:0] i_color = '0;
    logic [9:0]  i_h = '0;
    logic [9:0]  i_v = '0;
    logic        i_rendering = 1'b0;
    logic [9:0]  o_pointH, o_pointV;
    logic        o_pointVAL;
    logic [18:0] o_count;

    point_tracker dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_color(i_color), .i_h(i_h), .i_v(i_v),
        .i_rendering(i_rendering), .o_pointH(o_pointH), .o_pointV(o_pointV),
        .o_pointVAL(o_pointVAL), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [29:0] GREEN = {10'd0, 10'd1023, 10'd0};
    localparam logic [29:0] BLACK = 30'd0;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    // ---------------- reference model ----------------
    int  qh[$];
    int  qv[$];
    bit  in_frame, pend;
    int  e_ph, e_pv, e_cnt;
    bit  e_val;

    function automatic bit is_match(bit rend, int h, int v, logic [29:0] c);
        return rend && h < 640 && v < 480 &&
               int'(c[29:20]) <= 300 && int'(c[19:10]) >= 600 && int'(c[9:0]) <= 300;
    endfunction

    task automatic model_reset();
        qh.delete(); qv.delete();
        in_frame = 0; pend = 0;
        e_ph = 1023; e_pv = 1023; e_cnt = 0; e_val = 0;
    endtask

    task automatic model_step(bit rst, bit rend, int h, int v, logic [29:0] c);
        bit sof, eof;
        int mnh, mxh, mnv, mxv, ch, cv;
        if (rst) begin
            model_reset();
            return;
        end
        e_val = 0;
        if (pend) begin
            pend  = 0;
            e_cnt = qh.size();
            if (qh.size() >= 16) begin
                mnh = 1023; mxh = 0; mnv = 1023; mxv = 0;
                foreach (qh[i]) begin
                    if (qh[i] < mnh) mnh = qh[i];
                    if (qh[i] > mxh) mxh = qh[i];
                    if (qv[i] < mnv) mnv = qv[i];
                    if (qv[i] > mxv) mxv = qv[i];
                end
                ch = (mnh + mxh) / 2;
                cv = (mnv + mxv) / 2;
`ifdef POINT_SMOOTH_EN
                if (e_ph != 1023) begin
                    ch = (e_ph + ch) / 2;
                    cv = (e_pv + cv) / 2;
                end
`endif
                e_ph = ch; e_pv = cv; e_val = 1;
            end
        end else begin
            sof = rend && h == 0 && v == 0;
            eof = rend && h == 639 && v == 479;
            if (sof) begin
                in_frame = 1;
                qh.delete(); qv.delete();
            end
            if (in_frame && is_match(rend, h, v, c)) begin
                qh.push_back(h); qv.push_back(v);
            end
            if (in_frame && eof && !sof) begin
                pend = 1; in_frame = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pixel per clock; model advanced at the edge, outputs sampled 1 ns later.
    task automatic px(bit rst, bit rend, int h, int v, logic [29:0] c);
        longint act, exp;
        i_rst = rst; i_rendering = rend; i_h = 10'(h); i_v = 10'(v); i_color = c;
        @(posedge i_clk);
        model_step(rst, rend, h, v, c);
        #1;
        act = {o_pointVAL, o_pointH, o_pointV, o_count};
        exp = {e_val, 10'(e_ph), 10'(e_pv), 19'(e_cnt)};
        chk("cycle{val,H,V,count}", act, exp);
        if (o_pointVAL) pulses++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) px(0, 0, 0, 0, BLACK);
    endtask

    task automatic frame(int x0, int y0, int w, int hgt, bit rend);
        px(0, 1, 0, 0, BLACK);
        for (int y = y0; y < y0 + hgt; y++)
            for (int x = x0; x < x0 + w; x++)
                px(0, rend, x, y, GREEN);
        px(0, 1, 639, 479, BLACK);
        idle(3);
    endtask

    typedef struct {
        int x0, y0, w, hgt;
        bit rend;
        int cnt, ph, pv, np;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{x0:0,   y0:0,   w:0,  hgt:0,  rend:1, cnt:0,   ph:1023, pv:1023, np:0};
        tbl[1] = '{x0:100, y0:50,  w:20, hgt:10, rend:1, cnt:200, ph:109,  pv:54,   np:1};
        tbl[2] = '{x0:10,  y0:10,  w:3,  hgt:3,  rend:1, cnt:9,   ph:109,  pv:54,   np:0};
        tbl[3] = '{x0:100, y0:50,  w:20, hgt:10, rend:0, cnt:0,   ph:109,  pv:54,   np:0};
        tbl[4] = '{x0:700, y0:20,  w:4,  hgt:4,  rend:1, cnt:0,   ph:109,  pv:54,   np:0};
        tbl[5] = '{x0:623, y0:479, w:16, hgt:1,  rend:1, cnt:16,  ph:630,  pv:479,  np:1};
        tbl[6] = '{x0:200, y0:200, w:15, hgt:1,  rend:1, cnt:15,  ph:630,  pv:479,  np:0};
        tbl[7] = '{x0:0,   y0:0,   w:4,  hgt:4,  rend:1, cnt:16,  ph:1,    pv:1,    np:1};

        model_reset();
        px(1, 0, 0, 0, BLACK);
        px(1, 0, 0, 0, BLACK);
        chk("reset pointH", o_pointH, 1023);
        chk("reset pointV", o_pointV, 1023);
        chk("reset VAL", o_pointVAL, 0);
        chk("reset count", o_count, 0);

        for (int i = 0; i < 8; i++) begin
            pulses = 0;
            frame(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].hgt, tbl[i].rend);
            chk($sformatf("vec%0d count", i), o_count, tbl[i].cnt);
            chk($sformatf("vec%0d pointH", i), o_pointH, tbl[i].ph);
            chk($sformatf("vec%0d pointV", i), o_pointV, tbl[i].pv);
            chk($sformatf("vec%0d pulses", i), pulses, tbl[i].np);
        end

        // Exact pulse timing: EOF on edge N, pulse only after edge N+1.
        px(0, 1, 0, 0, BLACK);
        for (int x = 0; x < 16; x++) px(0, 1, 400 + x, 100, GREEN);
        px(0, 1, 639, 479, BLACK);
        chk("lat edge N", o_pointVAL, 0);
        px(0, 0, 0, 0, BLACK);
        chk("lat edge N+1", o_pointVAL, 1);
        chk("lat pointH", o_pointH, 407);
        px(0, 0, 0, 0, BLACK);
        chk("lat edge N+2", o_pointVAL, 0);

        // Mid-frame restart: matches before the second SOF are discarded.
        pulses = 0;
        px(0, 1, 0, 0, BLACK);
        for (int y = 100; y < 104; y++)
            for (int x = 300; x < 304; x++) px(0, 1, x, y, GREEN);
        px(0, 1, 5, 200, BLACK);
        px(0, 1, 0, 0, BLACK);
        for (int y = 300; y < 304; y++)
            for (int x = 500; x < 504; x++) px(0, 1, x, y, GREEN);
        px(0, 1, 639, 479, BLACK);
        idle(3);
        chk("restart count", o_count, 16);
        chk("restart pointH", o_pointH, 501);
        chk("restart pointV", o_pointV, 301);
        chk("restart pulses", pulses, 1);

        // Reset during SCAN: accumulation aborted, no report at the following EOF.
        pulses = 0;
        px(0, 1, 0, 0, BLACK);
        for (int x = 0; x < 20; x++) px(0, 1, 50 + x, 60, GREEN);
        px(1, 1, 70, 60, GREEN);
        chk("rst scan pointH", o_pointH, 1023);
        chk("rst scan count", o_count, 0);
        for (int x = 0; x < 20; x++) px(0, 1, 80 + x, 60, GREEN);
        px(0, 1, 639, 479, BLACK);
        idle(3);
        chk("rst scan pulses", pulses, 0);

        // Reset on the REPORT cycle clears the pending pulse.
        pulses = 0;
        px(0, 1, 0, 0, BLACK);
        for (int x = 0; x < 16; x++) px(0, 1, 10 + x, 10, GREEN);
        px(0, 1, 639, 479, BLACK);
        px(1, 0, 0, 0, BLACK);
        chk("rst report VAL", o_pointVAL, 0);
        chk("rst report pointV", o_pointV, 1023);
        idle(3);
        chk("rst report pulses", pulses, 0);

        // Randomised frames near the colour thresholds, checked by the model each cycle.
        for (int f = 0; f < 8; f++) begin
            px(0, 1, 0, 0, BLACK);
            for (int n = 0; n < 250; n++) begin
                logic [29:0] c;
                c = {10'($urandom_range(280, 320)), 10'($urandom_range(580, 620)),
                     10'($urandom_range(280, 320))};
                px(0, $urandom_range(0, 7) != 0, $urandom_range(0, 700),
                   $urandom_range(0, 520), c);
            end
            px(0, 1, 639, 479, BLACK);
            idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
